// File: rtl/vga_sync_if.sv
// Pixel-timing bundle from the VGA sync generator to its pixel consumer.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_tick;

  modport master (output p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_tick);
  modport slave  (input  p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_tick);
endinterface

// File: rtl/vga_sync_timing.sv
// VGA raster timing: pixel-rate divider, column/line counters and registered
// sync/blanking flags that stay cycle-coherent with the counters.
module vga_sync_timing #(
  parameter int unsigned DIV = 4,
  parameter int unsigned HV  = 640,
  parameter int unsigned HFP = 16,
  parameter int unsigned HSW = 96,
  parameter int unsigned HBP = 48,
  parameter int unsigned VV  = 480,
  parameter int unsigned VFP = 10,
  parameter int unsigned VSW = 2,
  parameter int unsigned VBP = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int unsigned PW     = 10;
  localparam int unsigned DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HT     = HV + HFP + HSW + HBP;
  localparam int unsigned VT     = VV + VFP + VSW + VBP;
  localparam int unsigned HS_BEG = HV + HFP;
  localparam int unsigned HS_END = HV + HFP + HSW - 1;
  localparam int unsigned VS_BEG = VV + VFP;
  localparam int unsigned VS_END = VV + VFP + VSW - 1;

  logic [DW-1:0] r_div_cnt;
  logic [PW-1:0] r_pix_x;
  logic [PW-1:0] r_pix_y;
  logic          r_p_tick;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;
  logic          r_frame_tick;

  logic [DW-1:0] w_div_nxt;
  logic [PW-1:0] w_x_nxt;
  logic [PW-1:0] w_y_nxt;
  logic          w_tick;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_p_tick_nxt;
  logic          w_hsync_nxt;
  logic          w_vsync_nxt;
  logic          w_video_on_nxt;

  // Next-state counters; flags are derived from these so they land with the counters.
  always_comb begin
    w_div_nxt      = '0;
    w_x_nxt        = r_pix_x;
    w_y_nxt        = r_pix_y;
    w_tick         = (r_div_cnt == DW'(DIV - 1));
    w_line_end     = w_tick && (r_pix_x == PW'(HT - 1));
    w_frame_end    = w_line_end && (r_pix_y == PW'(VT - 1));

    if (!w_tick) begin
      w_div_nxt = r_div_cnt + DW'(1);
    end
    if (w_tick) begin
      w_x_nxt = w_line_end ? '0 : r_pix_x + PW'(1);
    end
    if (w_line_end) begin
      w_y_nxt = w_frame_end ? '0 : r_pix_y + PW'(1);
    end

    w_p_tick_nxt   = (w_div_nxt == DW'(DIV - 1));
    w_hsync_nxt    = !((w_x_nxt >= PW'(HS_BEG)) && (w_x_nxt <= PW'(HS_END)));
    w_vsync_nxt    = !((w_y_nxt >= PW'(VS_BEG)) && (w_y_nxt <= PW'(VS_END)));
    w_video_on_nxt = (w_x_nxt < PW'(HV)) && (w_y_nxt < PW'(VV));
  end

  // Reset values describe pixel (0,0): visible, sync idle, no frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_p_tick     <= (DIV == 1);
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_video_on   <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_div_cnt    <= w_div_nxt;
      r_pix_x      <= w_x_nxt;
      r_pix_y      <= w_y_nxt;
      r_p_tick     <= w_p_tick_nxt;
      r_hsync      <= w_hsync_nxt;
      r_vsync      <= w_vsync_nxt;
      r_video_on   <= w_video_on_nxt;
      r_frame_tick <= w_frame_end;
    end
  end

  assign vga.p_tick     = r_p_tick;
  assign vga.pix_x      = r_pix_x;
  assign vga.pix_y      = r_pix_y;
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.video_on   = r_video_on;
  assign vga.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Directed bench: a shrunken raster (DIV=4, 32x13), a DIV=1 variant and the
// default 800x525 instance for reset release and one full line.
module tb_vga_sync_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_1;
  logic rst_d;
  int   checks   = 0;
  int   failures = 0;
  int   ec_s;
  int   ec_1;
  int   ec_d;

  vga_sync_if if_s ();
  vga_sync_if if_1 ();
  vga_sync_if if_d ();

  // Small raster: HT=32 (hsync x=20..25, visible x<16), VT=13 (vsync y=8..9, visible y<6).
  vga_sync_timing #(.DIV(4), .HV(16), .HFP(4), .HSW(6), .HBP(6),
                    .VV(6), .VFP(2), .VSW(2), .VBP(3))
    u_s (.clk(clk), .reset(rst_s), .vga(if_s));

  vga_sync_timing #(.DIV(1), .HV(16), .HFP(4), .HSW(6), .HBP(6),
                    .VV(6), .VFP(2), .VSW(2), .VBP(3))
    u_1 (.clk(clk), .reset(rst_1), .vga(if_1));

  vga_sync_timing u_d (.clk(clk), .reset(rst_d), .vga(if_d));

  // Edges since reset release, per instance.
  always @(posedge clk or posedge rst_s) if (rst_s) ec_s <= 0; else ec_s <= ec_s + 1;
  always @(posedge clk or posedge rst_1) if (rst_1) ec_1 <= 0; else ec_1 <= ec_1 + 1;
  always @(posedge clk or posedge rst_d) if (rst_d) ec_d <= 0; else ec_d <= ec_d + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_s(input int k);
    int guard;
    guard = 0;
    while (ec_s < k && guard < 20000) begin
      step();
      guard++;
    end
    checks++;
    if (ec_s !== k) begin
      failures++;
      $display("FAIL run_s edge got=%0d exp=%0d", ec_s, k);
    end
  endtask

  task automatic test_reset();
    int exp_x[4] = '{0, 0, 0, 1};
    int exp_t[4] = '{0, 0, 1, 0};
    step();
    checks++;
    if ({if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_tick, if_s.p_tick}
        !== {10'd0, 10'd0, 5'b11100}) begin
      failures++;
      $display("FAIL reset_hold got x=%0d y=%0d hs=%b vs=%b von=%b ft=%b pt=%b exp 0 0 1 1 1 0 0",
               if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_tick, if_s.p_tick);
    end
    @(negedge clk);
    rst_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({if_s.pix_x, if_s.p_tick, if_s.frame_tick} !== {10'(exp_x[i]), 1'(exp_t[i]), 1'b0}) begin
        failures++;
        $display("FAIL release_edge%0d got x=%0d pt=%b ft=%b exp x=%0d pt=%0d ft=0",
                 i + 1, if_s.pix_x, if_s.p_tick, if_s.frame_tick, exp_x[i], exp_t[i]);
      end
    end
    run_s(88);
    checks++;
    if ({if_s.pix_x, if_s.hsync, if_s.video_on} !== {10'd22, 2'b00}) begin
      failures++;
      $display("FAIL pre_reset got x=%0d hs=%b von=%b exp 22 0 0", if_s.pix_x, if_s.hsync, if_s.video_on);
    end
    @(negedge clk);
    rst_s = 1'b1;
    #1;
    checks++;
    if ({if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_tick, if_s.p_tick}
        !== {10'd0, 10'd0, 5'b11100}) begin
      failures++;
      $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b von=%b ft=%b pt=%b exp 0 0 1 1 1 0 0",
               if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_tick, if_s.p_tick);
    end
    @(negedge clk);
    rst_s = 1'b0;
  endtask

  task automatic test_line_wrap();
    run_s(383);
    checks++;
    if ({if_s.pix_x, if_s.pix_y, if_s.p_tick, if_s.hsync, if_s.video_on} !== {10'd31, 10'd2, 3'b110}) begin
      failures++;
      $display("FAIL line_end got x=%0d y=%0d pt=%b hs=%b von=%b exp 31 2 1 1 0",
               if_s.pix_x, if_s.pix_y, if_s.p_tick, if_s.hsync, if_s.video_on);
    end
    step();
    checks++;
    if ({if_s.pix_x, if_s.pix_y, if_s.p_tick, if_s.hsync, if_s.video_on} !== {10'd0, 10'd3, 3'b011}) begin
      failures++;
      $display("FAIL line_wrap got x=%0d y=%0d pt=%b hs=%b von=%b exp 0 3 0 1 1",
               if_s.pix_x, if_s.pix_y, if_s.p_tick, if_s.hsync, if_s.video_on);
    end
  endtask

  task automatic test_hsync();
    int n_hs  = 0;
    int n_vo  = 0;
    int bad_e = 0;
    for (int e = 384; e <= 511; e++) begin
      if (e > 384) step();
      if (if_s.hsync === 1'b0) n_hs++;
      if (if_s.video_on === 1'b0) n_vo++;
      if ((e == 463 || e == 488) && if_s.hsync !== 1'b1) bad_e = e;
      if ((e == 464 || e == 487) && if_s.hsync !== 1'b0) bad_e = e;
    end
    checks++;
    if (n_hs !== 24) begin
      failures++;
      $display("FAIL hsync_low_clks got=%0d exp=24", n_hs);
    end
    checks++;
    if (n_vo !== 64) begin
      failures++;
      $display("FAIL hblank_clks got=%0d exp=64", n_vo);
    end
    checks++;
    if (bad_e !== 0) begin
      failures++;
      $display("FAIL hsync_edges wrong level at edge %0d exp none", bad_e);
    end
  endtask

  task automatic test_frame();
    int nft = 0, ft1 = 0, ft2 = 0, n_vs = 0, n_von = 0, oor = 0, bad_e = 0;
    for (int e = 512; e <= 3328; e++) begin
      step();
      if (if_s.frame_tick === 1'b1) begin
        nft++;
        if (nft == 1) ft1 = e; else ft2 = e;
        if ({if_s.pix_x, if_s.pix_y, if_s.video_on} !== {20'd0, 1'b1}) bad_e = e;
      end
      if (if_s.pix_x >= 10'd32 || if_s.pix_y >= 10'd13) oor++;
      if (e >= 1664 && e <= 3327) begin
        if (if_s.vsync === 1'b0) n_vs++;
        if (if_s.video_on === 1'b1) n_von++;
      end
      if ((e == 2687 || e == 2944) && if_s.vsync !== 1'b1) bad_e = e;
      if ((e == 2688 || e == 2943) && if_s.vsync !== 1'b0) bad_e = e;
    end
    checks++;
    if ({nft, ft1, ft2} !== {32'd2, 32'd1664, 32'd3328}) begin
      failures++;
      $display("FAIL frame_ticks got n=%0d at %0d,%0d exp n=2 at 1664,3328", nft, ft1, ft2);
    end
    checks++;
    if (n_vs !== 256) begin
      failures++;
      $display("FAIL vsync_low_clks got=%0d exp=256", n_vs);
    end
    checks++;
    if (n_von !== 384) begin
      failures++;
      $display("FAIL visible_clks got=%0d exp=384", n_von);
    end
    checks++;
    if (oor !== 0) begin
      failures++;
      $display("FAIL counter_range got=%0d out-of-range samples exp=0", oor);
    end
    checks++;
    if (bad_e !== 0) begin
      failures++;
      $display("FAIL vsync_frame_points wrong value at edge %0d exp none", bad_e);
    end
  endtask

  task automatic test_mid_sync_reset();
    int nft = 0, ft1 = 0;
    run_s(4568);
    checks++;
    if ({if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on} !== {10'd22, 10'd9, 3'b000}) begin
      failures++;
      $display("FAIL in_sync got x=%0d y=%0d hs=%b vs=%b von=%b exp 22 9 0 0 0",
               if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on);
    end
    @(negedge clk);
    rst_s = 1'b1;
    #1;
    checks++;
    if ({if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_tick, if_s.p_tick}
        !== {10'd0, 10'd0, 5'b11100}) begin
      failures++;
      $display("FAIL mid_sync_reset got x=%0d y=%0d hs=%b vs=%b von=%b ft=%b pt=%b exp 0 0 1 1 1 0 0",
               if_s.pix_x, if_s.pix_y, if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_tick, if_s.p_tick);
    end
    step();
    step();
    @(negedge clk);
    rst_s = 1'b0;
    for (int e = 1; e <= 1664; e++) begin
      step();
      if (if_s.frame_tick === 1'b1) begin
        nft++;
        ft1 = e;
      end
    end
    checks++;
    if ({nft, ft1} !== {32'd1, 32'd1664}) begin
      failures++;
      $display("FAIL post_reset_frame got n=%0d last=%0d exp n=1 at 1664", nft, ft1);
    end
  endtask

  task automatic test_div1();
    int nft = 0, ft1 = 0, ft2 = 0, pt_low = 0, bad_e = 0;
    @(negedge clk);
    rst_1 = 1'b1;
    #1;
    checks++;
    if ({if_1.p_tick, if_1.pix_x, if_1.pix_y} !== {1'b1, 20'd0}) begin
      failures++;
      $display("FAIL div1_reset got pt=%b x=%0d y=%0d exp 1 0 0", if_1.p_tick, if_1.pix_x, if_1.pix_y);
    end
    @(negedge clk);
    rst_1 = 1'b0;
    for (int e = 1; e <= 832; e++) begin
      step();
      if (if_1.p_tick !== 1'b1) pt_low++;
      if (if_1.frame_tick === 1'b1) begin
        nft++;
        if (nft == 1) ft1 = e; else ft2 = e;
      end
      if (e == 1  && if_1.pix_x !== 10'd1) bad_e = e;
      if (e == 16 && if_1.video_on !== 1'b0) bad_e = e;
      if (e == 20 && if_1.hsync !== 1'b0) bad_e = e;
      if (e == 31 && {if_1.pix_x, if_1.pix_y} !== {10'd31, 10'd0}) bad_e = e;
      if (e == 32 && {if_1.pix_x, if_1.pix_y} !== {10'd0, 10'd1}) bad_e = e;
    end
    checks++;
    if (pt_low !== 0) begin
      failures++;
      $display("FAIL div1_ptick got %0d low cycles exp=0", pt_low);
    end
    checks++;
    if ({nft, ft1, ft2} !== {32'd2, 32'd416, 32'd832}) begin
      failures++;
      $display("FAIL div1_frames got n=%0d at %0d,%0d exp n=2 at 416,832", nft, ft1, ft2);
    end
    checks++;
    if (bad_e !== 0) begin
      failures++;
      $display("FAIL div1_points wrong value at edge %0d exp none", bad_e);
    end
  endtask

  task automatic test_default();
    int exp_x[4] = '{0, 0, 0, 1};
    int exp_t[4] = '{0, 0, 1, 0};
    int n_hs = 0, n_vo = 0, bad_e = 0;
    @(negedge clk);
    rst_d = 1'b0;
    while (ec_d < 2700) step();
    checks++;
    if ({if_d.pix_x, if_d.hsync, if_d.video_on} !== {10'd675, 2'b00}) begin
      failures++;
      $display("FAIL def_run got x=%0d hs=%b von=%b exp 675 0 0", if_d.pix_x, if_d.hsync, if_d.video_on);
    end
    @(negedge clk);
    rst_d = 1'b1;
    #1;
    checks++;
    if ({if_d.pix_x, if_d.pix_y, if_d.hsync, if_d.vsync, if_d.video_on, if_d.frame_tick, if_d.p_tick}
        !== {10'd0, 10'd0, 5'b11100}) begin
      failures++;
      $display("FAIL def_reset got x=%0d y=%0d hs=%b vs=%b von=%b ft=%b pt=%b exp 0 0 1 1 1 0 0",
               if_d.pix_x, if_d.pix_y, if_d.hsync, if_d.vsync, if_d.video_on, if_d.frame_tick, if_d.p_tick);
    end
    @(negedge clk);
    rst_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({if_d.pix_x, if_d.p_tick} !== {10'(exp_x[i]), 1'(exp_t[i])}) begin
        failures++;
        $display("FAIL def_release_edge%0d got x=%0d pt=%b exp x=%0d pt=%0d",
                 i + 1, if_d.pix_x, if_d.p_tick, exp_x[i], exp_t[i]);
      end
    end
    for (int e = 4; e <= 3203; e++) begin
      if (e > 4) step();
      if (if_d.hsync === 1'b0) n_hs++;
      if (if_d.video_on === 1'b0) n_vo++;
      if (e == 3199 && {if_d.pix_x, if_d.pix_y, if_d.p_tick} !== {10'd799, 10'd0, 1'b1}) bad_e = e;
      if (e == 3200 && {if_d.pix_x, if_d.pix_y, if_d.hsync, if_d.video_on} !== {10'd0, 10'd1, 2'b11}) bad_e = e;
    end
    checks++;
    if (n_hs !== 384) begin
      failures++;
      $display("FAIL def_hsync_clks got=%0d exp=384", n_hs);
    end
    checks++;
    if (n_vo !== 640) begin
      failures++;
      $display("FAIL def_hblank_clks got=%0d exp=640", n_vo);
    end
    checks++;
    if (bad_e !== 0) begin
      failures++;
      $display("FAIL def_line_wrap wrong value at edge %0d exp none", bad_e);
    end
  endtask

  initial begin
    rst_s = 1'b1;
    rst_1 = 1'b1;
    rst_d = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_1 = 1'b0;
    test_reset();
    test_line_wrap();
    test_hsync();
    test_frame();
    test_mid_sync_reset();
    test_div1();
    test_default();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
